fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the icache request and latches fetched words for decode.
// Output latch updates one cycle after ihit; a one-entry skid buffer absorbs a word fetched under stall.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h00000000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic        redirect,
   input  logic [2:0]  PCsrc,
   input  logic [31:0] br_target,
   input  logic [31:0] jr_target,
   input  logic [25:0] j_index,
   input  logic        stall,
   input  logic        halt,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic [31:0] npc_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_pc_q, w_pc_q_nxt;
   logic [31:0] r_npc_q, w_npc_q_nxt;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_skid_instr, w_skid_instr_nxt;
   logic [31:0] r_skid_pc, w_skid_pc_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_redir_pc;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign iREN       = (r_state == FETCH);
   assign imemaddr   = r_pc;
   assign instr_out  = r_instr;
   assign pc_out     = r_pc_q;
   assign npc_out    = r_npc_q;
   assign valid_out  = r_valid;

   // Jump region comes from the PC+4 of the instruction currently in decode.
   always_comb begin
      case (PCsrc)
         3'd1:    w_redir_pc = br_target;
         3'd2:    w_redir_pc = {r_npc_q[31:28], j_index, 2'b00};
         3'd3:    w_redir_pc = jr_target;
         default: w_redir_pc = w_pc_plus4;
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_instr_nxt      = r_instr;
      w_pc_q_nxt       = r_pc_q;
      w_npc_q_nxt      = r_npc_q;
      w_valid_nxt      = r_valid;
      w_skid_instr_nxt = r_skid_instr;
      w_skid_pc_nxt    = r_skid_pc;
      case (r_state)
         FETCH, HOLD: begin
            if (halt) begin
               w_state_nxt = HALTED;
               w_valid_nxt = 1'b0;
            end else if (redirect) begin
               w_state_nxt = FETCH;
               w_pc_nxt    = w_redir_pc;
               w_valid_nxt = 1'b0;
            end else if (r_state == HOLD) begin
               if (!stall) begin
                  w_state_nxt = FETCH;
                  w_instr_nxt = r_skid_instr;
                  w_pc_q_nxt  = r_skid_pc;
                  w_npc_q_nxt = r_skid_pc + 32'd4;
                  w_valid_nxt = 1'b1;
               end
            end else if (ihit) begin
               w_pc_nxt = w_pc_plus4;
               if (stall) begin
                  w_state_nxt      = HOLD;
                  w_skid_instr_nxt = imemload;
                  w_skid_pc_nxt    = r_pc;
               end else begin
                  w_instr_nxt = imemload;
                  w_pc_q_nxt  = r_pc;
                  w_npc_q_nxt = w_pc_plus4;
                  w_valid_nxt = 1'b1;
               end
            end else if (!stall) begin
               w_valid_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state      <= FETCH;
         r_pc         <= PC_INIT;
         r_instr      <= 32'd0;
         r_pc_q       <= 32'd0;
         r_npc_q      <= 32'd0;
         r_valid      <= 1'b0;
         r_skid_instr <= 32'd0;
         r_skid_pc    <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_instr      <= w_instr_nxt;
         r_pc_q       <= w_pc_q_nxt;
         r_npc_q      <= w_npc_q_nxt;
         r_valid      <= w_valid_nxt;
         r_skid_instr <= w_skid_instr_nxt;
         r_skid_pc    <= w_skid_pc_nxt;
      end
   end

endmodule
